// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU compare path.
//   state_t : controller state encoding (S_IDLE=0, S_RUN=1, S_DONE=2)
//   SLICE_W : bits of each operand consumed per comparator step
package alu_pkg;

    localparam int SLICE_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_cmp_ctrl_if.sv
// serial_cmp_ctrl_if
// Handshake and result bundle of the serial magnitude comparator.
//   start       : request, taken when ready=1
//   data_a/b    : operands, sampled on the accept cycle
//   ready       : controller idle
//   done        : one-cycle result-valid pulse
//   eq/gt/lt    : result flags, held until the next result or reset
//   steps_used  : slice evaluations consumed by the last compare
// master drives the request side, slave is the controller.
interface serial_cmp_ctrl_if #(
    parameter int WIDTH = 32
) ();

    localparam int CNT_W = $clog2(WIDTH / 2);

    logic             start;
    logic [WIDTH-1:0] data_a;
    logic [WIDTH-1:0] data_b;
    logic             ready;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;
    logic [CNT_W:0]   steps_used;

    modport master (
        output start, data_a, data_b,
        input  ready, done, eq, gt, lt, steps_used
    );

    modport slave (
        input  start, data_a, data_b,
        output ready, done, eq, gt, lt, steps_used
    );

endinterface

// File: rtl/comparator_2.sv
// comparator_2
// Combinational 2-bit magnitude comparator slice with a cascaded EQ/GT chain.
//   a, b    : operand pair for this slice
//   eq_in   : all more-significant pairs were equal
//   gt_in   : A already known greater from more-significant pairs
//   eq_out  : A == B through this slice
//   gt_out  : A > B through this slice
module comparator_2
    import alu_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               eq_in,
    input  logic               gt_in,
    output logic               eq_out,
    output logic               gt_out
);

    // Once a more-significant pair has decided the result, this slice can
    // only pass it through; it contributes only while the chain is still equal.
    assign eq_out = eq_in & (a == b);
    assign gt_out = gt_in | (eq_in & (a > b));

endmodule

// File: rtl/serial_cmp_ctrl.sv
// serial_cmp_ctrl
// Multi-cycle magnitude comparator: walks the operands two bits per cycle,
// MSB pair first, through one comparator_2 slice and stops as soon as the
// result is decided.
// Ports:
//   clock : rising-edge clock
//   reset : synchronous, active-low
//   bus   : serial_cmp_ctrl_if.slave (start/data_a/data_b in;
//           ready/done/eq/gt/lt/steps_used out)
// Configuration:
//   SERIAL_CMP_SIGNED_EN : when defined, two's-complement signed compare;
//                          otherwise unsigned.
module serial_cmp_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clock,
    input  logic               reset,
    serial_cmp_ctrl_if.slave   bus
);

    localparam int STEPS = WIDTH / 2;
    localparam int CNT_W = $clog2(WIDTH / 2);
    localparam logic [CNT_W:0] LAST_CNT = (CNT_W + 1)'(STEPS);

    state_t           state;
    state_t           state_nx;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic             chain_eq;
    logic             chain_gt;
    logic [CNT_W:0]   cnt;
    logic [CNT_W:0]   cnt_inc;
    logic             last_step;

    logic             slice_eq;
    logic             slice_gt;

    logic             res_eq;
    logic             res_gt;
    logic             res_lt;
    logic [CNT_W:0]   res_steps;

`ifdef SERIAL_CMP_SIGNED_EN
    // Flipping the sign bit maps two's-complement order onto unsigned order,
    // so the rest of the datapath stays unsigned.
    assign load_a = {~bus.data_a[WIDTH-1], bus.data_a[WIDTH-2:0]};
    assign load_b = {~bus.data_b[WIDTH-1], bus.data_b[WIDTH-2:0]};
`else
    assign load_a = bus.data_a;
    assign load_b = bus.data_b;
`endif

    assign cnt_inc   = cnt + {{CNT_W{1'b0}}, 1'b1};
    assign last_step = (cnt_inc == LAST_CNT);

    comparator_2 u_slice (
        .a      (sh_a[WIDTH-1 -: SLICE_W]),
        .b      (sh_b[WIDTH-1 -: SLICE_W]),
        .eq_in  (chain_eq),
        .gt_in  (chain_gt),
        .eq_out (slice_eq),
        .gt_out (slice_gt)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and handshake outputs. RUN leaves as soon as the
    // chain goes unequal, because lower pairs can no longer change the result.
    always_comb begin
        state_nx  = state;
        bus.ready = 1'b0;
        bus.done  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                if (!slice_eq || last_step) begin
                    state_nx = S_DONE;
                end
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Operand shifters, compare chain and step counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            sh_a     <= '0;
            sh_b     <= '0;
            chain_eq <= 1'b0;
            chain_gt <= 1'b0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        sh_a     <= load_a;
                        sh_b     <= load_b;
                        chain_eq <= 1'b1;
                        chain_gt <= 1'b0;
                        cnt      <= '0;
                    end
                end
                S_RUN: begin
                    chain_eq <= slice_eq;
                    chain_gt <= slice_gt;
                    sh_a     <= {sh_a[WIDTH-SLICE_W-1:0], {SLICE_W{1'b0}}};
                    sh_b     <= {sh_b[WIDTH-SLICE_W-1:0], {SLICE_W{1'b0}}};
                    cnt      <= cnt_inc;
                end
                default: begin
                end
            endcase
        end
    end

    // Result holding registers. They are loaded on the RUN exit edge from the
    // slice outputs, which is the same value the chain registers take, so the
    // flags are already valid during the DONE cycle and then hold.
    always_ff @(posedge clock) begin
        if (!reset) begin
            res_eq    <= 1'b0;
            res_gt    <= 1'b0;
            res_lt    <= 1'b0;
            res_steps <= '0;
        end else if (state == S_RUN && state_nx == S_DONE) begin
            res_eq    <= slice_eq;
            res_gt    <= slice_gt;
            res_lt    <= ~slice_eq & ~slice_gt;
            res_steps <= cnt_inc;
        end
    end

    assign bus.eq         = res_eq;
    assign bus.gt         = res_gt;
    assign bus.lt         = res_lt;
    assign bus.steps_used = res_steps;

endmodule

// File: tb/tb_serial_cmp_ctrl.sv
// tb_serial_cmp_ctrl
// Directed bench for serial_cmp_ctrl with a queue of expected results built
// from an independent reference model of the compare.
module tb_serial_cmp_ctrl;

    localparam int W     = 32;
    localparam int STEPS = W / 2;

    typedef struct {
        logic [31:0] eq;
        logic [31:0] gt;
        logic [31:0] lt;
        logic [31:0] steps;
        logic [31:0] lat;
    } exp_t;

    logic clock;
    logic reset;

    int testCount;
    int failCount;
    exp_t sb[$];

    serial_cmp_ctrl_if #(.WIDTH(W)) bus ();

    serial_cmp_ctrl #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: native compare for the flags, first differing
    // 2-bit pair from the top for the step count.
    function automatic exp_t modelCmp(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic found;
        found = 1'b0;
`ifdef SERIAL_CMP_SIGNED_EN
        e.gt = 32'($signed(a) > $signed(b));
`else
        e.gt = 32'(a > b);
`endif
        e.eq    = 32'(a == b);
        e.lt    = 32'((a != b) && (e.gt == 32'd0));
        e.steps = 32'(STEPS);
        for (int i = 0; i < STEPS; i++) begin
            if (!found && (a[W-1-2*i -: 2] != b[W-1-2*i -: 2])) begin
                found   = 1'b1;
                e.steps = 32'(i + 1);
            end
        end
        e.lat = e.steps + 32'd1;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts one compare from an IDLE cycle, then scrambles the operand
    // pins right after the accept edge.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        check("ready_before_start", 32'(bus.ready), 32'd1);
        bus.start  = 1'b1;
        bus.data_a = a;
        bus.data_b = b;
        sb.push_back(modelCmp(a, b));
        @(posedge clock);
        #1;
        bus.start  = 1'b0;
        bus.data_a = ~a;
        bus.data_b = b ^ 32'h5A5A_C3C3;
    endtask

    // Waits (bounded) for done, compares against the oldest expected
    // result, then checks done drops and the flags hold in IDLE.
    task automatic checkOutput(input string tag, input int startLat);
        exp_t e;
        int lat;
        logic seen;
        lat  = startLat;
        seen = 1'b0;
        check({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            while (!seen && lat < 40) begin
                @(negedge clock);
                lat++;
                if (bus.done) seen = 1'b1;
            end
            check({tag, "_done_seen"}, 32'(seen), 32'd1);
            if (seen) begin
                check({tag, "_latency"}, 32'(lat), e.lat);
                check({tag, "_eq"}, 32'(bus.eq), e.eq);
                check({tag, "_gt"}, 32'(bus.gt), e.gt);
                check({tag, "_lt"}, 32'(bus.lt), e.lt);
                check({tag, "_steps"}, 32'(bus.steps_used), e.steps);
                check({tag, "_onehot"}, 32'($onehot({bus.eq, bus.gt, bus.lt})), 32'd1);
                @(negedge clock);
                check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
                check({tag, "_ready_back"}, 32'(bus.ready), 32'd1);
                check({tag, "_eq_hold"}, 32'(bus.eq), e.eq);
                check({tag, "_steps_hold"}, 32'(bus.steps_used), e.steps);
            end
        end
    endtask

    initial begin
        int doneCount;
        testCount  = 0;
        failCount  = 0;
        reset      = 1'b0;
        bus.start  = 1'b1;
        bus.data_a = 32'hC000_0000;
        bus.data_b = 32'h4000_0000;

        // Reset held with start high: nothing accepted, outputs cleared.
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ready", 32'(bus.ready), 32'd1);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_eq", 32'(bus.eq), 32'd0);
        check("rst_gt", 32'(bus.gt), 32'd0);
        check("rst_lt", 32'(bus.lt), 32'd0);
        check("rst_steps", 32'(bus.steps_used), 32'd0);
        bus.start = 1'b0;
        reset     = 1'b1;
        @(negedge clock);
        check("post_rst_ready", 32'(bus.ready), 32'd1);
        check("post_rst_done", 32'(bus.done), 32'd0);

        // Early decide on the top pair.
        applyStimulus(32'hC000_0000, 32'h4000_0000);
        checkOutput("early_gt", 0);

        // Full-length runs.
        applyStimulus(32'h1234_5678, 32'h1234_5678);
        checkOutput("full_eq", 0);
        applyStimulus(32'h0000_0001, 32'h0000_0002);
        checkOutput("full_lt", 0);

        // Sign-bit case: result depends on the build.
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001);
        checkOutput("sign_bit", 0);

        // Mid-width decision and a few random pairs.
        applyStimulus(32'h00A0_0000, 32'h00B0_0000);
        checkOutput("mid_lt", 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus($urandom, $urandom);
            checkOutput("random", 0);
        end

        // start pulsed with new operands while busy is ignored.
        applyStimulus(32'hA5A5_0F0F, 32'hA5A5_0F0F);
        @(negedge clock);
        check("busy_ready", 32'(bus.ready), 32'd0);
        bus.start  = 1'b1;
        bus.data_a = 32'h0000_0000;
        bus.data_b = 32'hFFFF_FFFF;
        @(negedge clock);
        bus.start = 1'b0;
        checkOutput("busy", 2);

        // start held high: the next compare is taken in the IDLE cycle after done.
        @(negedge clock);
        bus.start  = 1'b1;
        bus.data_a = 32'hC000_0000;
        bus.data_b = 32'h4000_0000;
        sb.push_back(modelCmp(32'hC000_0000, 32'h4000_0000));
        @(negedge clock);
        check("b2b_ready_run", 32'(bus.ready), 32'd0);
        bus.data_a = 32'h4000_0000;
        bus.data_b = 32'hC000_0000;
        sb.push_back(modelCmp(32'h4000_0000, 32'hC000_0000));
        checkOutput("b2b_first", 1);
        @(posedge clock);
        #1;
        bus.start = 1'b0;
        check("b2b_ready_low", 32'(bus.ready), 32'd0);
        checkOutput("b2b_second", 0);

        // Reset in the fifth cycle of a full-length compare.
        applyStimulus(32'h8765_4321, 32'h8765_4321);
        repeat (4) @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("midrst_ready", 32'(bus.ready), 32'd1);
        check("midrst_done", 32'(bus.done), 32'd0);
        check("midrst_eq", 32'(bus.eq), 32'd0);
        check("midrst_gt", 32'(bus.gt), 32'd0);
        check("midrst_lt", 32'(bus.lt), 32'd0);
        check("midrst_steps", 32'(bus.steps_used), 32'd0);
        reset = 1'b1;
        void'(sb.pop_front());
        doneCount = 0;
        repeat (20) begin
            @(negedge clock);
            if (bus.done) doneCount++;
        end
        check("midrst_no_done", 32'(doneCount), 32'd0);
        applyStimulus(32'h0000_0003, 32'h0000_0002);
        checkOutput("after_rst", 0);

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
